// File: rtl/ex_stage.sv
// Execute stage: operand forwarding mux, single-cycle RV32I ALU, iterative
// RV32M divide/remainder, and the EX/MEM pipeline register.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | single-cycle ops pass through; a valid divide is latched here
// S_DIV_RUN  | restoring division on magnitudes, one quotient bit per cycle
// S_DIV_DONE | sign fix / forced result applied, result loaded into EX/MEM
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            use_imm,
    input  logic [1:0]      forwardA,
    input  logic [1:0]      forwardB,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic [XLEN-1:0] wb_fwd_data,
    input  logic [4:0]      in_rd,
    input  logic            in_regwrite,
    input  logic            flush,
    output logic            stall,
    output logic            out_valid,
    output logic            out_regwrite,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_result
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DIV_RUN  = 2'd1,
        S_DIV_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [5:0]      cnt;

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;

    // Latched divide context
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] dvs_r;
    logic [XLEN-1:0] dividend_r;
    logic            rem_op_r;
    logic            neg_q_r;
    logic            neg_r_r;
    logic            div_zero_r;
    logic            div_ovf_r;
    logic [4:0]      rd_r;
    logic            regwrite_r;

    logic            is_div;
    logic            div_start;
    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN:0]   partial;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] div_res;

    // Operand selection: 11 falls back to the register file like 00
    always_comb begin
        case (forwardA)
            2'b01:   op_a = mem_fwd_data;
            2'b10:   op_a = wb_fwd_data;
            default: op_a = rs1_data;
        endcase
        case (forwardB)
            2'b01:   fwd_b = mem_fwd_data;
            2'b10:   fwd_b = wb_fwd_data;
            default: fwd_b = rs2_data;
        endcase
        op_b = use_imm ? imm : fwd_b;
    end

    // Single-cycle ALU; undefined and divide codes produce 0 here
    always_comb begin
        case (alu_op)
            OP_ADD:   alu_res = op_a + op_b;
            OP_SUB:   alu_res = op_a - op_b;
            OP_SLL:   alu_res = op_a << op_b[4:0];
            OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_XOR:   alu_res = op_a ^ op_b;
            OP_SRL:   alu_res = op_a >> op_b[4:0];
            OP_SRA:   alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
            OP_OR:    alu_res = op_a | op_b;
            OP_AND:   alu_res = op_a & op_b;
            OP_PASSB: alu_res = op_b;
            default:  alu_res = '0;
        endcase
    end

    // Divide decode: codes 12..15; bit 0 clear means signed, bit 1 set means remainder
    always_comb begin
        is_div    = (alu_op[3:2] == 2'b11);
        div_start = (state == S_IDLE) && in_valid && is_div;
        signed_op = ~alu_op[0];
        a_neg     = signed_op & op_a[XLEN-1];
        b_neg     = signed_op & op_b[XLEN-1];
    end

    // Pipeline hold: never while reset or flush are asserted
    assign stall = !rst && !flush && ((state == S_DIV_RUN) || div_start);

    // One restoring step, plus the final sign fix and special-case override
    always_comb begin
        partial = {rem_r, quo_r[XLEN-1]};
        diff    = partial - {1'b0, dvs_r};
        quo_fix = neg_q_r ? (~quo_r + 1'b1) : quo_r;
        rem_fix = neg_r_r ? (~rem_r + 1'b1) : rem_r;
        if (div_zero_r) begin
            quo_fix = '1;
            rem_fix = dividend_r;
        end else if (div_ovf_r) begin
            quo_fix = MIN_NEG;
            rem_fix = '0;
        end
        div_res = rem_op_r ? rem_fix : quo_fix;
    end

    // FSM, divider datapath and EX/MEM register
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            out_valid    <= 1'b0;
            out_regwrite <= 1'b0;
            out_rd       <= '0;
            out_result   <= '0;
            quo_r        <= '0;
            rem_r        <= '0;
            dvs_r        <= '0;
            dividend_r   <= '0;
            rem_op_r     <= 1'b0;
            neg_q_r      <= 1'b0;
            neg_r_r      <= 1'b0;
            div_zero_r   <= 1'b0;
            div_ovf_r    <= 1'b0;
            rd_r         <= '0;
            regwrite_r   <= 1'b0;
        end else if (flush) begin
            state        <= S_IDLE;
            cnt          <= '0;
            out_valid    <= 1'b0;
            out_regwrite <= 1'b0;
            out_rd       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && !is_div) begin
                        out_valid    <= 1'b1;
                        out_regwrite <= in_regwrite;
                        out_rd       <= in_rd;
                        out_result   <= alu_res;
                    end else begin
                        out_valid    <= 1'b0;
                        out_regwrite <= 1'b0;
                        out_rd       <= '0;
                    end
                    if (div_start) begin
                        state      <= S_DIV_RUN;
                        cnt        <= 6'd31;
                        quo_r      <= a_neg ? (~op_a + 1'b1) : op_a;
                        rem_r      <= '0;
                        dvs_r      <= b_neg ? (~op_b + 1'b1) : op_b;
                        dividend_r <= op_a;
                        rem_op_r   <= alu_op[1];
                        neg_q_r    <= a_neg ^ b_neg;
                        neg_r_r    <= a_neg;
                        div_zero_r <= (op_b == '0);
                        div_ovf_r  <= signed_op && (op_a == MIN_NEG) && (op_b == '1);
                        rd_r       <= in_rd;
                        regwrite_r <= in_regwrite;
                    end
                end
                S_DIV_RUN: begin
                    out_valid    <= 1'b0;
                    out_regwrite <= 1'b0;
                    out_rd       <= '0;
                    rem_r        <= diff[XLEN] ? partial[XLEN-1:0] : diff[XLEN-1:0];
                    quo_r        <= {quo_r[XLEN-2:0], ~diff[XLEN]};
                    if (cnt == 6'd0) begin
                        state <= S_DIV_DONE;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                S_DIV_DONE: begin
                    state        <= S_IDLE;
                    out_valid    <= 1'b1;
                    out_regwrite <= regwrite_r;
                    out_rd       <= rd_r;
                    out_result   <= div_res;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: vector table driven through a scoreboard, plus
// hand-written flush and reset-during-divide sequences.
module tb_ex_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  alu_op;
    logic [31:0] rs1_data, rs2_data, imm;
    logic        use_imm;
    logic [1:0]  forwardA, forwardB;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic        flush;
    logic        stall;
    logic        out_valid, out_regwrite;
    logic [4:0]  out_rd;
    logic [31:0] out_result;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs1, rs2, imm;
        logic        use_imm;
        logic [1:0]  fa, fb;
        logic [31:0] memd, wbd;
        logic [4:0]  rd;
        logic        regwr;
        logic [31:0] exp;
        logic        tog;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        regwr;
        logic [31:0] res;
    } exp_t;

    localparam int NV = 26;
    vec_t vecs[NV];
    exp_t sb[$];
    exp_t mon_e;

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_op(alu_op),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .use_imm(use_imm),
        .forwardA(forwardA), .forwardB(forwardB),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
        .in_rd(in_rd), .in_regwrite(in_regwrite), .flush(flush),
        .stall(stall), .out_valid(out_valid), .out_regwrite(out_regwrite),
        .out_rd(out_rd), .out_result(out_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] im, input logic ui, input logic [1:0] fa,
                                input logic [1:0] fb, input logic [31:0] memd, input logic [31:0] wbd,
                                input logic [4:0] rd, input logic regwr, input logic [31:0] exp,
                                input logic tog);
        vec_t v;
        v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.imm = im; v.use_imm = ui;
        v.fa = fa; v.fb = fb; v.memd = memd; v.wbd = wbd;
        v.rd = rd; v.regwr = regwr; v.exp = exp; v.tog = tog;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Scoreboard consumer: every EX/MEM valid must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got res=%h rd=%0d", out_result, out_rd);
            end else begin
                mon_e = sb.pop_front();
                if (out_result !== mon_e.res || out_rd !== mon_e.rd || out_regwrite !== mon_e.regwr) begin
                    failures++;
                    $display("FAIL exmem_out got res=%h rd=%0d rw=%b expected res=%h rd=%0d rw=%b",
                             out_result, out_rd, out_regwrite, mon_e.res, mon_e.rd, mon_e.regwr);
                end
            end
        end
    end

    task automatic drive(input vec_t v);
        alu_op = v.op; rs1_data = v.rs1; rs2_data = v.rs2; imm = v.imm;
        use_imm = v.use_imm; forwardA = v.fa; forwardB = v.fb;
        mem_fwd_data = v.memd; wb_fwd_data = v.wbd;
        in_rd = v.rd; in_regwrite = v.regwr; in_valid = 1'b1;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        exp_t e;
        int   cnt;
        v = vecs[idx];
        @(posedge clk); #1;
        drive(v);
        e.rd = v.rd; e.regwr = v.regwr; e.res = v.exp;
        sb.push_back(e);
        if (v.op >= 4'd12) begin
            cnt = 0;
            for (int g = 0; g < 60; g++) begin
                @(negedge clk);
                if (!stall) break;
                cnt++;
                if (v.tog && cnt == 5) wb_fwd_data = 32'h0000_0064;
                @(posedge clk); #1;
            end
            chk($sformatf("div_stall_cycles_vec%0d", idx), cnt, 33);
        end else begin
            @(negedge clk);
            chk($sformatf("no_stall_vec%0d", idx), {31'b0, stall}, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(4'd0,  32'd5,        32'd7,        32'd0,        0, 2'b01, 2'b00, 32'd100, 32'd0, 5'd1, 1, 32'd107, 0);
        vecs[1]  = mk(4'd1,  32'd1,        32'd0,        32'hFFFFFFFF, 1, 2'b00, 2'b10, 32'd0, 32'd3, 5'd2, 1, 32'd2, 0);
        vecs[2]  = mk(4'd7,  32'h80000000, 32'd0,        32'd4,        1, 2'b00, 2'b00, 32'd0, 32'd0, 5'd3, 1, 32'hF8000000, 0);
        vecs[3]  = mk(4'd2,  32'd1,        32'h25,       32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd4, 1, 32'h20, 0);
        vecs[4]  = mk(4'd3,  32'hFFFFFFFF, 32'd1,        32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd5, 1, 32'd1, 0);
        vecs[5]  = mk(4'd4,  32'hFFFFFFFF, 32'd1,        32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd6, 1, 32'd0, 0);
        vecs[6]  = mk(4'd5,  32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd7, 1, 32'hFF00FF00, 0);
        vecs[7]  = mk(4'd6,  32'h80000000, 32'h1F,       32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd8, 1, 32'd1, 0);
        vecs[8]  = mk(4'd8,  32'h12340000, 32'h00005678, 32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd9, 1, 32'h12345678, 0);
        vecs[9]  = mk(4'd9,  32'hFF00FF00, 32'h0F0F0F0F, 32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd10, 1, 32'h0F000F00, 0);
        vecs[10] = mk(4'd10, 32'd0,        32'd0,        32'd0,        0, 2'b00, 2'b01, 32'hDEADBEEF, 32'd0, 5'd11, 1, 32'hDEADBEEF, 0);
        vecs[11] = mk(4'd11, 32'd5,        32'd6,        32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd12, 0, 32'd0, 0);
        vecs[12] = mk(4'd0,  32'hFFFFFFFF, 32'd2,        32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd13, 1, 32'd1, 0);
        vecs[13] = mk(4'd0,  32'd10,       32'd20,       32'd0,        0, 2'b11, 2'b11, 32'd99, 32'd77, 5'd14, 1, 32'd30, 0);
        vecs[14] = mk(4'd12, 32'd0,        32'd2,        32'd0,        0, 2'b10, 2'b00, 32'd0, 32'hFFFFFFF9, 5'd15, 1, 32'hFFFFFFFD, 1);
        vecs[15] = mk(4'd14, 32'hFFFFFFF9, 32'd2,        32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd16, 1, 32'hFFFFFFFF, 0);
        vecs[16] = mk(4'd13, 32'h12345678, 32'd0,        32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd17, 1, 32'hFFFFFFFF, 0);
        vecs[17] = mk(4'd14, 32'd13,       32'd0,        32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd18, 1, 32'd13, 0);
        vecs[18] = mk(4'd12, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd19, 1, 32'h80000000, 0);
        vecs[19] = mk(4'd14, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd20, 1, 32'd0, 0);
        vecs[20] = mk(4'd15, 32'd100,      32'd7,        32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd21, 1, 32'd2, 0);
        vecs[21] = mk(4'd13, 32'hFFFFFFFF, 32'd16,       32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd22, 1, 32'h0FFFFFFF, 0);
        vecs[22] = mk(4'd12, 32'd7,        32'hFFFFFFFE, 32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd23, 1, 32'hFFFFFFFD, 0);
        vecs[23] = mk(4'd14, 32'd7,        32'hFFFFFFFE, 32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd24, 1, 32'd1, 0);
        vecs[24] = mk(4'd12, 32'hFFFFFFF9, 32'd0,        32'd0,        0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd25, 1, 32'hFFFFFFFF, 0);
        vecs[25] = mk(4'd12, 32'd100,      32'd0,        32'd10,       1, 2'b00, 2'b00, 32'd0, 32'd0, 5'd26, 0, 32'd10, 0);

        // Reset, with a divide presented so stall masking by rst is exercised
        rst = 1'b1; flush = 1'b0;
        drive(vecs[14]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", {31'b0, stall}, 0);
        chk("reset_out_valid", {31'b0, out_valid}, 0);
        chk("reset_out_regwrite", {31'b0, out_regwrite}, 0);
        chk("reset_out_rd", {27'b0, out_rd}, 0);
        chk("reset_out_result", out_result, 0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i);

        // Flush on cycle 10 of a divide
        @(posedge clk); #1;
        drive(vecs[15]);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("stall_before_flush", {31'b0, stall}, 1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("stall_in_flush_cycle", {31'b0, stall}, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("stall_after_flush", {31'b0, stall}, 0);
        chk("bubble_after_flush", {31'b0, out_valid}, 0);
        run_vec(0);
        repeat (40) @(posedge clk);

        // Reset on cycle 20 of a divide
        #1;
        drive(vecs[22]);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("stall_during_rst", {31'b0, stall}, 0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_div_stall", {31'b0, stall}, 0);
        chk("rst_mid_div_valid", {31'b0, out_valid}, 0);
        chk("rst_mid_div_regwrite", {31'b0, out_regwrite}, 0);
        chk("rst_mid_div_rd", {27'b0, out_rd}, 0);
        chk("rst_mid_div_result", out_result, 0);
        repeat (40) @(posedge clk);
        run_vec(12);
        repeat (3) @(posedge clk);

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
